maf_cal_pipe: RTL
=================

// Module: maf_cal_pipe
// PURPOSE
//  Pipelined, lane-parametrised mantissa-combine stage of the MAF datapath. Per lane: merges aligned addend
//  high part with the multiplier/compressor sum, applies effective-sign extension and carry-in, emits packed
//  pre-inversion result. Sits between CSA/compressor output and the inverter/LZA stage; valid/ready both sides.
// PARAMETERS
//  SUM_W  48  compressor sum width; must be divisible by NLANE
//  HI_W   26  aligned-addend high-part width; must be divisible by NLANE
//  NLANE  2   max SIMD lanes (1,2,4); LMW = max(1,$clog2(NLANE))
//  TAG_W  4   sideband tag width, passed through unchanged
//  P_W = SUM_W+HI_W+1 (derived, 75 default)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  flush      in   1      sync: drop all in-flight transactions
//  in_valid   in   1      input transaction valid
//  in_ready   out  1      input accepted when in_valid&&in_ready
//  lanes_log2 in   LMW    active lanes L=2^lanes_log2
//  addend_hi  in   HI_W   aligned addend high part (from shifter)
//  sum        in   SUM_W  compressor sum; lane top bit = carry for L>1
//  cin        in   1      carry-in, used only when L==1
//  s_a,s_b,s_c in  NLANE  per-lane operand signs
//  in_tag     in   TAG_W  sideband
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream ready
//  out_p      out  P_W    packed result
//  out_err    out  1      lanes_log2 > log2(NLANE)
//  out_tag    out  TAG_W  tag of this result
// BEHAVIOUR
//  Reset: out_valid=0, out_p=0, out_err=0, out_tag=0, both stage valids 0; in_ready=1 after reset.
//  Pipe: S1 input register, S2 compute+output register. Accept->out_valid latency exactly 2 cycles, 1 txn/cycle.
//  S2 loads when !out_valid||out_ready; S1 moves to S2 when S2 loads; in_ready=!s1_valid||s1_move (comb).
//  out_ready=0 with out_valid=1: out_p/out_err/out_tag held stable; max 2 txns in flight; order preserved.
//  flush: clears s1_valid and out_valid next edge; same-cycle input not accepted (in_ready=0 while flush).
//  Lane j (0..L-1): hs=HI_W/L, ss=SUM_W/L, hi_j=addend_hi[j*hs+:hs], sum_j=sum[j*ss+:ss],
//   sgn_j=s_a[j]^s_b[j]^s_c[j] (effective sub).
//  L==1: out_p[P_W-1:SUM_W] = ({sgn_0,hi_0}+cin) mod 2^(HI_W+1); out_p[SUM_W-1:0]=sum.
//  L>1 : slot width hs+ss at out_p[j*(hs+ss)+:hs+ss] = {({sgn_j,hi_j}+sum_j[ss-1]) mod 2^(hs+1), sum_j[ss-2:0]};
//   out_p[P_W-1] = 0.
//  Unused sign bits (j>=L) ignored. Invalid lanes_log2: out_p=0, out_err=1, txn still flows (no stall).
//  lanes_log2 sampled per txn at accept; mode may change every txn.
//  Reset mid-operation: async clear of all valids; in-flight data discarded, no partial output.
// STRUCTURE
//  maf_pkg: lane-mode localparams (LM_1, LM_2, LM_4), P_W calc function, slot-offset function.
//  Sub-module maf_cal_lane (comb: sign XOR, hs+1 wide add with carry, slot concat), generated per
//   lane-count option; top muxes by registered lanes_log2 and owns handshake/pipeline regs.
// TESTING (default params)
//  L=1: hi=26'h0000001, signs 0,0,1, cin=1, sum=48'h0000000000FF -> 2 cyc later
//   out_p={27'h4000002,48'h0000000000FF}, err=0.
//  L=1 wrap: hi=26'h3FFFFFF, signs 1,1,1, cin=1, sum=0 -> out_p=0.
//  L=2: hi={13'h1FFF,13'h0001}, sum={24'h000003,24'h800005}, s_a=2'b10, s_b=s_c=0
//   -> out_p={1'b0,14'h3FFF,23'h3,14'h0002,23'h5}.
//  Backpressure: 4 txns tags 0..3 back-to-back, out_ready=0 for 3 cycles from first out_valid
//   -> in_ready drops after 2 held; all 4 delivered in order, no dup/loss.
//  lanes_log2=2 (NLANE=2) -> out_err=1, out_p=0; next valid txn unaffected.
//  rst pulse while out_valid=1 and S1 full -> out_valid=0 immediately; next accept appears 2 cycles later.
//  flush with 2 in flight -> no output for them; txn accepted next cycle emerges with correct tag.

Source files
------------

// File: rtl/maf_pkg.sv
// ---------------------------------------------------------------------------
// maf_pkg
// Shared constants and elaboration-time helpers for the MAF mantissa-combine
// stage (maf_cal_pipe / maf_cal_lane).
//   LM_1/LM_2/LM_4 : lanes_log2 encodings for 1, 2 and 4 active lanes
//   calc_p_w       : packed result width (sum + addend high part + sign bit)
//   calc_lmw       : width of the lanes_log2 port
//   slot_off       : bit offset of lane j's slot inside the packed result
// ---------------------------------------------------------------------------
package maf_pkg;

    localparam int LM_1 = 0;
    localparam int LM_2 = 1;
    localparam int LM_4 = 2;

    function automatic int calc_p_w(input int sum_w, input int hi_w);
        return sum_w + hi_w + 1;
    endfunction

    // Always at least 2 bits so that every lane mode (1,2,4) can be requested
    // on any configuration; modes above the built lane count are reported
    // through out_err instead of being unrepresentable.
    function automatic int calc_lmw(input int nlane);
        int c;
        c = $clog2(nlane);
        return (c > 2) ? c : 2;
    endfunction

    function automatic int slot_off(input int j, input int hs, input int ss);
        return j * (hs + ss);
    endfunction

endpackage

// File: rtl/maf_cal_lane.sv
// ---------------------------------------------------------------------------
// maf_cal_lane
// Combinational per-lane combine: effective-sign XOR, (HS+1)-bit add of
// {sign, addend high part} with a single carry bit, then concatenation with
// the low sum bits that pass straight through.
// Ports:
//   hi       in  HS      addend high part for this lane
//   lo       in  LO_W    sum bits copied unchanged below the high part
//   s_a/b/c  in  1       operand signs for this lane
//   carry    in  1       carry added into the high part
//   slot     out HS+1+LO_W  {({sgn,hi}+carry) mod 2^(HS+1), lo}
// ---------------------------------------------------------------------------
module maf_cal_lane #(
    parameter int HS   = 26,
    parameter int LO_W = 48
) (
    input  logic [HS-1:0]      hi,
    input  logic [LO_W-1:0]    lo,
    input  logic               s_a,
    input  logic               s_b,
    input  logic               s_c,
    input  logic               carry,
    output logic [HS+LO_W:0]   slot
);

    logic          sgn;
    logic [HS:0]   hi_res;

    // Odd number of negative operands means an effective subtraction.
    assign sgn    = s_a ^ s_b ^ s_c;
    // Wraps modulo 2^(HS+1); the carry out of the sign position is dropped.
    assign hi_res = {sgn, hi} + {{HS{1'b0}}, carry};
    assign slot   = {hi_res, lo};

endmodule

// File: rtl/maf_cal_pipe.sv
// ---------------------------------------------------------------------------
// maf_cal_pipe
// Two-stage valid/ready pipeline for the MAF mantissa-combine step. Stage 1
// registers the input transaction; stage 2 computes the lane-packed
// pre-inversion result from the stage-1 registers and holds it as output.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               drop every in-flight transaction at the next edge
//   in_valid/in_ready   input handshake
//   lanes_log2          active lane count L = 2^lanes_log2 (per transaction)
//   addend_hi, sum, cin datapath operands (cin used only when L==1)
//   s_a, s_b, s_c       per-lane operand signs
//   in_tag / out_tag    sideband passed through unchanged
//   out_valid/out_ready output handshake
//   out_p               packed result, out_err = unsupported lane mode
// ---------------------------------------------------------------------------
module maf_cal_pipe
    import maf_pkg::*;
#(
    parameter int SUM_W = 48,
    parameter int HI_W  = 26,
    parameter int NLANE = 2,
    parameter int TAG_W = 4,
    localparam int LMW  = calc_lmw(NLANE),
    localparam int P_W  = calc_p_w(SUM_W, HI_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LMW-1:0]   lanes_log2,
    input  logic [HI_W-1:0]  addend_hi,
    input  logic [SUM_W-1:0] sum,
    input  logic             cin,
    input  logic [NLANE-1:0] s_a,
    input  logic [NLANE-1:0] s_b,
    input  logic [NLANE-1:0] s_c,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P_W-1:0]   out_p,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    // One result candidate per supported lane count (1, 2, ... NLANE).
    localparam int NMODE = $clog2(NLANE) + 1;

    // ---------------- stage 1 registers ----------------
    logic             s1_valid_reg;
    logic [LMW-1:0]   s1_lanes_reg;
    logic [HI_W-1:0]  s1_hi_reg;
    logic [SUM_W-1:0] s1_sum_reg;
    logic             s1_cin_reg;
    logic [NLANE-1:0] s1_sa_reg;
    logic [NLANE-1:0] s1_sb_reg;
    logic [NLANE-1:0] s1_sc_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    // ---------------- handshake ----------------
    logic s2_load;
    logic s1_move;
    logic accept;

    assign s2_load  = !out_valid || out_ready;
    assign s1_move  = s1_valid_reg && s2_load;
    // Flush takes priority: nothing is accepted in the flush cycle.
    assign in_ready = !flush && (!s1_valid_reg || s1_move);
    assign accept   = in_valid && in_ready;

    // ---------------- per-mode datapath ----------------
    logic [P_W-1:0] mode_p [NMODE];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NMODE; gi++) begin : g_mode
            localparam int L  = 1 << gi;
            localparam int HS = HI_W / L;
            localparam int SS = SUM_W / L;

            logic [P_W-1:0] p_k;

            if (gi == LM_1) begin : g_single
                // Full-width sum passes through; external carry-in feeds the add.
                maf_cal_lane #(
                    .HS   (HI_W),
                    .LO_W (SUM_W)
                ) u_lane (
                    .hi    (s1_hi_reg),
                    .lo    (s1_sum_reg),
                    .s_a   (s1_sa_reg[0]),
                    .s_b   (s1_sb_reg[0]),
                    .s_c   (s1_sc_reg[0]),
                    .carry (s1_cin_reg),
                    .slot  (p_k)
                );
            end else begin : g_multi
                assign p_k[P_W-1] = 1'b0;
                for (gj = 0; gj < L; gj++) begin : g_lane
                    // The top bit of each sum slice is that lane's carry, so only
                    // the lower SS-1 bits are copied into the slot.
                    maf_cal_lane #(
                        .HS   (HS),
                        .LO_W (SS - 1)
                    ) u_lane (
                        .hi    (s1_hi_reg[gj*HS +: HS]),
                        .lo    (s1_sum_reg[gj*SS +: SS-1]),
                        .s_a   (s1_sa_reg[gj]),
                        .s_b   (s1_sb_reg[gj]),
                        .s_c   (s1_sc_reg[gj]),
                        .carry (s1_sum_reg[gj*SS + SS - 1]),
                        .slot  (p_k[slot_off(gj, HS, SS) +: HS+SS])
                    );
                end
            end

            assign mode_p[gi] = p_k;
        end
    endgenerate

    // Select by the lane mode captured with the transaction; anything above
    // the built lane count yields a zero result flagged as an error.
    logic [P_W-1:0] res_p;
    logic           res_err;

    always_comb begin
        res_p   = '0;
        res_err = 1'b1;
        for (int k = 0; k < NMODE; k++) begin
            if (s1_lanes_reg == LMW'(k)) begin
                res_p   = mode_p[k];
                res_err = 1'b0;
            end
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_lanes_reg <= '0;
            s1_hi_reg    <= '0;
            s1_sum_reg   <= '0;
            s1_cin_reg   <= 1'b0;
            s1_sa_reg    <= '0;
            s1_sb_reg    <= '0;
            s1_sc_reg    <= '0;
            s1_tag_reg   <= '0;
            out_valid    <= 1'b0;
            out_p        <= '0;
            out_err      <= 1'b0;
            out_tag      <= '0;
        end else if (flush) begin
            s1_valid_reg <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_lanes_reg <= lanes_log2;
                s1_hi_reg    <= addend_hi;
                s1_sum_reg   <= sum;
                s1_cin_reg   <= cin;
                s1_sa_reg    <= s_a;
                s1_sb_reg    <= s_b;
                s1_sc_reg    <= s_c;
                s1_tag_reg   <= in_tag;
            end else if (s1_move) begin
                s1_valid_reg <= 1'b0;
            end

            if (s2_load) begin
                out_valid <= s1_valid_reg;
                // Payload only changes when a real transaction moves in, so a
                // bubble leaves the last result visible but not valid.
                if (s1_valid_reg) begin
                    out_p   <= res_p;
                    out_err <= res_err;
                    out_tag <= s1_tag_reg;
                end
            end
        end
    end

endmodule
